camera_frame_writer: RTL and testbench
======================================

# camera_frame_writer

Downstream stage of the camera pixel converter: it takes the RGB332 pixel stream with the camera's href/vsync timing and writes complete frames into a two-bank (ping-pong) frame-buffer RAM. It generates write address, data and enable. It hands each completed bank to the display reader through a level/pulse handshake, so the display never reads a bank that is being written.

## Interface
Parameters:
- H_ACTIVE, 320, pixels stored per line
- V_ACTIVE, 240, lines stored per frame
- ADDR_W, 18, RAM address width; must hold 2*H_ACTIVE*V_ACTIVE

Ports:
- pclk  in  1  camera pixel clock; one clock for the whole block
- reset  in  1  synchronous, active-high
- href  in  1  line-active from camera
- vsync  in  1  frame sync from camera (high = vertical blank)
- pix_valid  in  1  one-cycle strobe: pix_data holds a converted pixel
- pix_data  in  8  RGB332 pixel
- rd_busy  in  1  display is reading display_bank (level)
- wr_addr  out  ADDR_W  RAM write address
- wr_data  out  8  RAM write data
- wr_en  out  1  RAM write enable
- wr_bank  out  1  bank currently being written
- display_bank  out  1  bank the display must read
- frame_done  out  1  one-cycle pulse on bank swap
- drop_cnt  out  8  completed frames discarded because rd_busy was high (saturating)
- short_cnt  out  8  frames discarded because they were incomplete (saturating)

## Operation
- State machine: IDLE, SYNC, CAPTURE.
- IDLE: entered on reset. Waits for vsync rising → SYNC. Pixels are ignored.
- SYNC: waits for vsync falling → CAPTURE. On entry, x=0, y=0 and the address base is set to wr_bank*H_ACTIVE*V_ACTIVE.
- CAPTURE, pixel handling:
  - When pix_valid=1, href=1 and vsync=0: if x<H_ACTIVE and y<V_ACTIVE, write the pixel at base + y*H_ACTIVE + x, then x++.
  - Pixels with x≥H_ACTIVE or y≥V_ACTIVE are dropped. x saturates at H_ACTIVE.
- CAPTURE, line end: on href falling, if x>0 then y++ (saturates at V_ACTIVE) and x=0. A line with x=0 does not advance y.
- CAPTURE, frame end: on vsync rising, the frame is complete iff y==V_ACTIVE. Next state is SYNC.
  - Complete and rd_busy=0: swap wr_bank and display_bank; pulse frame_done.
  - Complete and rd_busy=1: no swap; drop_cnt++. The next frame overwrites the same bank.
  - Incomplete: no swap; short_cnt++.
- Addressing is incremental (running line-base register plus x). No multiplier.
- wr_bank and display_bank are always complementary.
- Same-cycle events:
  - vsync rising with pix_valid: vsync takes priority; the pixel is dropped.
  - href falling with pix_valid: the pixel is written first, then the line advances.
- Reset mid-frame: the partial frame is abandoned. Nothing is swapped or counted.

## Timing
- Reset values:
  - State: IDLE.
  - wr_addr=0, wr_data=0, wr_en=0.
  - wr_bank=0, display_bank=1.
  - frame_done=0, drop_cnt=0, short_cnt=0.
- Write latency: wr_addr, wr_data and wr_en are registered, 1 pclk after the accepted pix_valid. wr_en is high for exactly one cycle per stored pixel.
- Swap decision: wr_bank, display_bank and frame_done change 1 cycle after the pclk on which vsync rising is detected. rd_busy is sampled on that same detection cycle.
- Edge detection uses registered copies of href and vsync, so an edge is acted on the cycle after the input changes.
- The display may deassert rd_busy at any time; it takes effect only at the next frame end.

## Structure
- The shared camera package holds:
  - State enum (IDLE, SYNC, CAPTURE)
  - H_ACTIVE/V_ACTIVE defaults
  - RGB332 pixel typedef
  - Saturating-counter width constant
- One sub-module, fb_addr_gen, holds the x/y counters, line base and bank base, with inputs step, line_end, frame_start and bank. The FSM, handshake and error counters stay in the top.

## Test plan
- Full frame: H_ACTIVE=4, V_ACTIVE=3, 12 pixels over 3 href lines, rd_busy=0 → wr_en pulses at addresses 0..11. At vsync: frame_done pulses, wr_bank=1, display_bank=0.
- Second frame into bank 1 → addresses 12..23; wr_bank returns to 0.
- Full frame with rd_busy=1 at vsync → no frame_done, drop_cnt=1. The next frame rewrites the same addresses.
- Overlong line (6 pixels, H=4) plus a 4th line → only 4 writes per line, 12 writes total; the frame completes normally.
- Only 2 lines, then vsync → short_cnt=1, banks unchanged. Asserting reset mid-line → all outputs return to their reset values and the first vsync after reset is ignored until SYNC.

Source files
------------

// File: rtl/camera_frame_writer_pkg.sv
// Shared camera package.
// Holds the frame-writer state enum, default frame geometry, the RGB332
// pixel type and the width and increment helper for the saturating
// error counters.
package camera_frame_writer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SYNC    = 2'd1,
        ST_CAPTURE = 2'd2
    } cfw_state_t;

    localparam int H_ACTIVE_DEFAULT = 320;
    localparam int V_ACTIVE_DEFAULT = 240;
    localparam int ADDR_W_DEFAULT   = 18;

    typedef logic [7:0] rgb332_t;

    localparam int SAT_CNT_W = 8;

    // Increment that sticks at all-ones instead of wrapping to zero.
    function automatic logic [SAT_CNT_W-1:0] sat_inc(input logic [SAT_CNT_W-1:0] value);
        return (&value) ? value : value + SAT_CNT_W'(1);
    endfunction

endpackage

// File: rtl/fb_addr_gen.sv
// Frame-buffer address generator.
// Tracks the x/y position inside the frame being written and forms the RAM
// address incrementally from a running line-base register, so no multiplier
// is needed.
//   pclk, reset  : clock and synchronous active-high reset
//   step         : a candidate pixel arrived this cycle
//   line_end     : href falling edge seen this cycle
//   frame_start  : rewind to the top of the frame in bank 'bank'
//   bank         : bank that the next frame is written into
//   addr         : address of the current pixel position
//   wr_ok        : current position lies inside the active window
//   frame_full   : all V_ACTIVE lines have been stored
module fb_addr_gen
    import camera_frame_writer_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEFAULT,
    parameter int V_ACTIVE = V_ACTIVE_DEFAULT,
    parameter int ADDR_W   = ADDR_W_DEFAULT
) (
    input  logic              pclk,
    input  logic              reset,
    input  logic              step,
    input  logic              line_end,
    input  logic              frame_start,
    input  logic              bank,
    output logic [ADDR_W-1:0] addr,
    output logic              wr_ok,
    output logic              frame_full
);

    localparam int X_W = $clog2(H_ACTIVE + 1);
    localparam int Y_W = $clog2(V_ACTIVE + 1);
    localparam logic [X_W-1:0]    X_MAX     = X_W'(H_ACTIVE);
    localparam logic [Y_W-1:0]    Y_MAX     = Y_W'(V_ACTIVE);
    localparam logic [ADDR_W-1:0] LINE_STEP = ADDR_W'(H_ACTIVE);
    localparam logic [ADDR_W-1:0] BANK_SIZE = ADDR_W'(H_ACTIVE * V_ACTIVE);

    logic [X_W-1:0]    x_q, x_d;
    logic [Y_W-1:0]    y_q, y_d;
    logic [ADDR_W-1:0] line_base_q, line_base_d;
    logic [X_W-1:0]    x_after;

    assign wr_ok      = (x_q < X_MAX) && (y_q < Y_MAX);
    assign frame_full = (y_q == Y_MAX);
    assign addr       = line_base_q + ADDR_W'(x_q);

    // x only advances on a stored pixel, so it parks at H_ACTIVE. A pixel
    // arriving together with line_end is counted before the line closes,
    // and a line that stored nothing leaves y and the line base untouched.
    always_comb begin
        x_d         = x_q;
        y_d         = y_q;
        line_base_d = line_base_q;
        x_after     = x_q;
        if (step && wr_ok) begin
            x_after = x_q + X_W'(1);
        end
        if (frame_start) begin
            x_d         = '0;
            y_d         = '0;
            line_base_d = bank ? BANK_SIZE : '0;
        end else if (line_end) begin
            x_d = '0;
            if ((x_after != '0) && (y_q < Y_MAX)) begin
                y_d         = y_q + Y_W'(1);
                line_base_d = line_base_q + LINE_STEP;
            end
        end else begin
            x_d = x_after;
        end
    end

    always_ff @(posedge pclk) begin
        if (reset) begin
            x_q         <= '0;
            y_q         <= '0;
            line_base_q <= '0;
        end else begin
            x_q         <= x_d;
            y_q         <= y_d;
            line_base_q <= line_base_d;
        end
    end

endmodule

// File: rtl/camera_frame_writer.sv
// Camera frame writer.
// Writes the RGB332 pixel stream into a ping-pong frame buffer and hands
// each completed bank to the display reader.
//   pclk, reset        : pixel clock, synchronous active-high reset
//   href, vsync        : camera line-active / vertical-blank timing
//   pix_valid,pix_data : one-cycle pixel strobe and RGB332 pixel
//   rd_busy            : display is still reading display_bank
//   wr_addr/data/en    : registered RAM write port
//   wr_bank            : bank being written; display_bank is its complement
//   frame_done         : one-cycle pulse when the banks swap
//   drop_cnt           : complete frames discarded because rd_busy was high
//   short_cnt          : incomplete frames discarded
module camera_frame_writer
    import camera_frame_writer_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEFAULT,
    parameter int V_ACTIVE = V_ACTIVE_DEFAULT,
    parameter int ADDR_W   = ADDR_W_DEFAULT
) (
    input  logic                 pclk,
    input  logic                 reset,
    input  logic                 href,
    input  logic                 vsync,
    input  logic                 pix_valid,
    input  logic [7:0]           pix_data,
    input  logic                 rd_busy,
    output logic [ADDR_W-1:0]    wr_addr,
    output logic [7:0]           wr_data,
    output logic                 wr_en,
    output logic                 wr_bank,
    output logic                 display_bank,
    output logic                 frame_done,
    output logic [SAT_CNT_W-1:0] drop_cnt,
    output logic [SAT_CNT_W-1:0] short_cnt
);

    cfw_state_t state_q, state_d;

    logic href_q, href_d;
    logic vsync_q, vsync_d;

    logic [ADDR_W-1:0]    wr_addr_q, wr_addr_d;
    rgb332_t              wr_data_q, wr_data_d;
    logic                 wr_en_q, wr_en_d;
    logic                 wr_bank_q, wr_bank_d;
    logic                 frame_done_q, frame_done_d;
    logic [SAT_CNT_W-1:0] drop_cnt_q, drop_cnt_d;
    logic [SAT_CNT_W-1:0] short_cnt_q, short_cnt_d;

    logic              vsync_rise;
    logic              vsync_fall;
    logic              href_fall;
    logic              pix_step;
    logic              line_end;
    logic              frame_start;
    logic              pix_write;
    logic [ADDR_W-1:0] gen_addr;
    logic              gen_wr_ok;
    logic              gen_frame_full;

    assign vsync_rise = vsync && !vsync_q;
    assign vsync_fall = !vsync && vsync_q;
    assign href_fall  = !href && href_q;
    assign pix_write  = pix_step && gen_wr_ok;

    // The generator is handed the bank the next frame will use, so a swap
    // and the rewind to the new bank base happen on the same edge.
    fb_addr_gen #(
        .H_ACTIVE (H_ACTIVE),
        .V_ACTIVE (V_ACTIVE),
        .ADDR_W   (ADDR_W)
    ) u_addr_gen (
        .pclk        (pclk),
        .reset       (reset),
        .step        (pix_step),
        .line_end    (line_end),
        .frame_start (frame_start),
        .bank        (wr_bank_d),
        .addr        (gen_addr),
        .wr_ok       (gen_wr_ok),
        .frame_full  (gen_frame_full)
    );

    // Next-state logic. A vsync rising edge in CAPTURE closes the frame and
    // suppresses any pixel of that cycle. rd_busy only matters at that
    // instant; a frame the display is still reading is dropped and the
    // same bank is overwritten by the next frame.
    always_comb begin
        state_d      = state_q;
        href_d       = href;
        vsync_d      = vsync;
        wr_bank_d    = wr_bank_q;
        frame_done_d = 1'b0;
        drop_cnt_d   = drop_cnt_q;
        short_cnt_d  = short_cnt_q;
        pix_step     = 1'b0;
        line_end     = 1'b0;
        frame_start  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (vsync_rise) begin
                    state_d     = ST_SYNC;
                    frame_start = 1'b1;
                end
            end
            ST_SYNC: begin
                if (vsync_fall) begin
                    state_d = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                if (vsync_rise) begin
                    state_d     = ST_SYNC;
                    frame_start = 1'b1;
                    if (!gen_frame_full) begin
                        short_cnt_d = sat_inc(short_cnt_q);
                    end else if (rd_busy) begin
                        drop_cnt_d = sat_inc(drop_cnt_q);
                    end else begin
                        wr_bank_d    = !wr_bank_q;
                        frame_done_d = 1'b1;
                    end
                end else begin
                    pix_step = pix_valid && href && !vsync;
                    line_end = href_fall;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // RAM write port: registered one cycle after an accepted pixel, address
    // and data hold their last value between writes.
    always_comb begin
        wr_en_d   = pix_write;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        if (pix_write) begin
            wr_addr_d = gen_addr;
            wr_data_d = rgb332_t'(pix_data);
        end
    end

    // The href/vsync history is sampled even during reset so that a vsync
    // already high when reset drops is not mistaken for a rising edge.
    always_ff @(posedge pclk) begin
        href_q  <= href_d;
        vsync_q <= vsync_d;
        if (reset) begin
            state_q      <= ST_IDLE;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            wr_en_q      <= 1'b0;
            wr_bank_q    <= 1'b0;
            frame_done_q <= 1'b0;
            drop_cnt_q   <= '0;
            short_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            wr_en_q      <= wr_en_d;
            wr_bank_q    <= wr_bank_d;
            frame_done_q <= frame_done_d;
            drop_cnt_q   <= drop_cnt_d;
            short_cnt_q  <= short_cnt_d;
        end
    end

    assign wr_addr      = wr_addr_q;
    assign wr_data      = wr_data_q;
    assign wr_en        = wr_en_q;
    assign wr_bank      = wr_bank_q;
    assign display_bank = !wr_bank_q;
    assign frame_done   = frame_done_q;
    assign drop_cnt     = drop_cnt_q;
    assign short_cnt    = short_cnt_q;

endmodule

// File: tb/tb_camera_frame_writer.sv
// Testbench for camera_frame_writer with a 4x3 frame.
// A monitor logs every RAM write and frame_done pulse; each frame scenario
// from the vector table is driven and the logged writes, bank state and
// error counters are compared with values computed from the table.
module tb_camera_frame_writer;

    localparam int H  = 4;
    localparam int V  = 3;
    localparam int AW = 5;

    logic          pclk = 1'b0;
    logic          reset;
    logic          href;
    logic          vsync;
    logic          pix_valid;
    logic [7:0]    pix_data;
    logic          rd_busy;
    logic [AW-1:0] wr_addr;
    logic [7:0]    wr_data;
    logic          wr_en;
    logic          wr_bank;
    logic          display_bank;
    logic          frame_done;
    logic [7:0]    drop_cnt;
    logic [7:0]    short_cnt;

    int checks = 0;
    int errors = 0;
    int fdCount = 0;

    logic [AW-1:0] addrLog[$];
    logic [7:0]    dataLog[$];

    typedef struct {
        int lines;
        int ppl;
        int busy;
        int emptyLine;
        int expWrites;
        int expBase;
        int expFd;
        int expWrBank;
        int expDrop;
        int expShort;
    } frameVec_t;

    frameVec_t vecs[7];

    camera_frame_writer #(
        .H_ACTIVE (H),
        .V_ACTIVE (V),
        .ADDR_W   (AW)
    ) dut (
        .pclk         (pclk),
        .reset        (reset),
        .href         (href),
        .vsync        (vsync),
        .pix_valid    (pix_valid),
        .pix_data     (pix_data),
        .rd_busy      (rd_busy),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .wr_en        (wr_en),
        .wr_bank      (wr_bank),
        .display_bank (display_bank),
        .frame_done   (frame_done),
        .drop_cnt     (drop_cnt),
        .short_cnt    (short_cnt)
    );

    // Free-running pixel clock.
    always #5 pclk = ~pclk;

    // Log every write and frame_done pulse, sampled on the falling edge.
    always @(negedge pclk) begin
        if (wr_en) begin
            addrLog.push_back(wr_addr);
            dataLog.push_back(wr_data);
        end
        if (frame_done) begin
            fdCount++;
        end
    end

    function automatic logic [7:0] pattern(int f, int l, int x);
        return 8'((f % 8) * 32 + (l % 4) * 8 + (x % 8));
    endfunction

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    task automatic checkOutput(string name, int actual, int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
        end
    endtask

    task automatic checkResetValues(string tag);
        checkOutput({tag, " wr_en"}, int'(wr_en), 0);
        checkOutput({tag, " wr_addr"}, int'(wr_addr), 0);
        checkOutput({tag, " wr_data"}, int'(wr_data), 0);
        checkOutput({tag, " wr_bank"}, int'(wr_bank), 0);
        checkOutput({tag, " display_bank"}, int'(display_bank), 1);
        checkOutput({tag, " frame_done"}, int'(frame_done), 0);
        checkOutput({tag, " drop_cnt"}, int'(drop_cnt), 0);
        checkOutput({tag, " short_cnt"}, int'(short_cnt), 0);
    endtask

    // One href line: pixels x = firstX..ppl-1 on alternate cycles.
    task automatic driveLine(int f, int l, int ppl, int firstX);
        href = 1'b1;
        if (firstX == 0) begin
            tick();
        end
        for (int x = firstX; x < ppl; x++) begin
            pix_valid = 1'b1;
            pix_data  = pattern(f, l, x);
            tick();
            pix_valid = 1'b0;
            tick();
        end
        href = 1'b0;
        repeat (3) tick();
    endtask

    task automatic vsyncPulse();
        vsync = 1'b1;
        repeat (3) tick();
        vsync = 1'b0;
        repeat (3) tick();
    endtask

    // Compare the writes logged since startIdx and the end-of-frame state.
    task automatic checkFrame(string tag, int f, int startIdx, int fdStart, frameVec_t v);
        int n;
        int lMax;
        int xMax;
        n    = 0;
        lMax = (v.lines < V) ? v.lines : V;
        xMax = (v.ppl < H) ? v.ppl : H;
        checkOutput({tag, " writes"}, addrLog.size() - startIdx, v.expWrites);
        for (int l = 0; l < lMax; l++) begin
            for (int x = 0; x < xMax; x++) begin
                if (startIdx + n < addrLog.size()) begin
                    checkOutput($sformatf("%s addr%0d", tag, n), int'(addrLog[startIdx + n]),
                                v.expBase + l * H + x);
                    checkOutput($sformatf("%s data%0d", tag, n), int'(dataLog[startIdx + n]),
                                int'(pattern(f, l, x)));
                end
                n++;
            end
        end
        checkOutput({tag, " frame_done"}, fdCount - fdStart, v.expFd);
        checkOutput({tag, " wr_bank"}, int'(wr_bank), v.expWrBank);
        checkOutput({tag, " display_bank"}, int'(display_bank), 1 - v.expWrBank);
        checkOutput({tag, " drop_cnt"}, int'(drop_cnt), v.expDrop);
        checkOutput({tag, " short_cnt"}, int'(short_cnt), v.expShort);
    endtask

    // Drive one table frame, end it with a vsync pulse, then compare.
    task automatic applyStimulus(int idx);
        int startIdx;
        int fdStart;
        startIdx = addrLog.size();
        fdStart  = fdCount;
        rd_busy  = (vecs[idx].busy != 0);
        for (int l = 0; l < vecs[idx].lines; l++) begin
            driveLine(idx, l, vecs[idx].ppl, 0);
            if (l == 0 && vecs[idx].emptyLine != 0) begin
                href = 1'b1;
                repeat (2) tick();
                href = 1'b0;
                repeat (3) tick();
            end
        end
        vsyncPulse();
        rd_busy = 1'b0;
        checkFrame($sformatf("s%0d", idx), idx, startIdx, fdStart, vecs[idx]);
    endtask

    initial begin
        int startIdx;
        int fdStart;
        frameVec_t rv;

        //          lines ppl busy empty writes base fd bank drop short
        vecs[0] = '{3, 4, 0, 0, 12,  0, 1, 1, 0, 0};
        vecs[1] = '{3, 4, 0, 0, 12, 12, 1, 0, 0, 0};
        vecs[2] = '{3, 4, 1, 0, 12,  0, 0, 0, 1, 0};
        vecs[3] = '{3, 4, 0, 0, 12,  0, 1, 1, 1, 0};
        vecs[4] = '{4, 6, 0, 0, 12, 12, 1, 0, 1, 0};
        vecs[5] = '{2, 4, 0, 0,  8,  0, 0, 0, 1, 1};
        vecs[6] = '{3, 4, 0, 1, 12,  0, 1, 1, 1, 1};

        reset     = 1'b1;
        href      = 1'b0;
        vsync     = 1'b0;
        pix_valid = 1'b0;
        pix_data  = 8'h00;
        rd_busy   = 1'b0;
        repeat (3) tick();
        checkResetValues("por");
        reset = 1'b0;
        tick();

        // Leading vsync takes the writer from IDLE into CAPTURE.
        vsyncPulse();

        for (int i = 0; i < 7; i++) begin
            applyStimulus(i);
        end

        // Reset in the middle of a line abandons everything.
        href = 1'b1;
        tick();
        for (int x = 0; x < 2; x++) begin
            pix_valid = 1'b1;
            pix_data  = pattern(3, 0, x);
            tick();
            pix_valid = 1'b0;
            tick();
        end
        reset     = 1'b1;
        pix_valid = 1'b1;
        tick();
        checkResetValues("midline");
        tick();
        reset     = 1'b0;
        pix_valid = 1'b0;
        href      = 1'b0;
        repeat (3) tick();

        // Lines before the first vsync are ignored in IDLE.
        startIdx = addrLog.size();
        fdStart  = fdCount;
        driveLine(5, 0, 4, 0);
        checkOutput("idle writes", addrLog.size() - startIdx, 0);
        vsyncPulse();
        checkOutput("idle frame_done", fdCount - fdStart, 0);
        checkOutput("idle short_cnt", int'(short_cnt), 0);

        // Full frame after reset, first pixel checked cycle by cycle.
        startIdx = addrLog.size();
        fdStart  = fdCount;
        href = 1'b1;
        tick();
        pix_valid = 1'b1;
        pix_data  = pattern(7, 0, 0);
        @(negedge pclk);
        checkOutput("lat wr_en before", int'(wr_en), 0);
        tick();
        pix_valid = 1'b0;
        @(negedge pclk);
        checkOutput("lat wr_en", int'(wr_en), 1);
        checkOutput("lat wr_addr", int'(wr_addr), 0);
        checkOutput("lat wr_data", int'(wr_data), int'(pattern(7, 0, 0)));
        tick();
        @(negedge pclk);
        checkOutput("lat wr_en after", int'(wr_en), 0);
        tick();
        driveLine(7, 0, 4, 1);
        driveLine(7, 1, 4, 0);
        driveLine(7, 2, 4, 0);
        vsyncPulse();
        rv = '{3, 4, 0, 0, 12, 0, 1, 1, 0, 0};
        checkFrame("post", 7, startIdx, fdStart, rv);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
